// File: rtl/decrypt_pipe_param_if.sv
// Packet-in / result-out handshake bundle for decrypt_pipe_param.
// The master drives packets and output-ready; the slave (the pipe) drives ready and results.
interface decrypt_pipe_param_if #(
  parameter int unsigned DATA_W  = 60,
  parameter int unsigned KEY_W   = 11,
  parameter int unsigned KEY_LSB = 6
) ();
  localparam int unsigned PKT_W = KEY_LSB + KEY_W + DATA_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [PKT_W-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W:0]   out_data;
  logic              out_err;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/decrypt_pipe_param.sv
// Two-stage key-mask decrypt/encrypt pipe: stage 1 expands the key into a mask,
// stage 2 subtracts (decrypt) or adds (encrypt) it, with valid/ready flow control and counters.
module decrypt_pipe_param #(
  parameter int unsigned     DATA_W  = 60,
  parameter int unsigned     KEY_W   = 11,
  parameter int unsigned     KEY_LSB = 6,
  parameter int unsigned     NSEG    = 6,
  parameter logic [NSEG-1:0] PATTERN = 6'b010110,
  parameter int unsigned     CNT_W   = 16
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  decrypt_pipe_param_if.slave    bus,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       pkt_cnt,
  output logic [CNT_W-1:0]       err_cnt
);
  localparam int unsigned PKT_W = KEY_LSB + KEY_W + DATA_W + 1;
  localparam int unsigned SEG_W = NSEG * KEY_W;

  logic [KEY_W-1:0]  key;
  logic [DATA_W:0]   y_in;
  logic [SEG_W-1:0]  seg_mask;
  logic [DATA_W-1:0] mask;
  logic              unused_bits;

  assign key  = bus.in_data[KEY_LSB +: KEY_W];
  assign y_in = bus.in_data[PKT_W-1 -: DATA_W+1];

  // Segments are built at full width; the top one is truncated by the slice below.
  always_comb begin
    seg_mask = '0;
    for (int unsigned i = 0; i < NSEG; i++) begin
      seg_mask[i*KEY_W +: KEY_W] = PATTERN[i] ? ~key : key;
    end
  end

  assign mask        = seg_mask[DATA_W-1:0];
  assign unused_bits = ^{seg_mask, bus.in_data};

  logic s1_v, s2_v;
  logic adv1, adv2;
  logic out_fire;

  assign adv2         = !s2_v || bus.out_ready;
  assign adv1         = !s1_v || adv2;
  assign bus.in_ready = adv1;
  assign out_fire     = s2_v && bus.out_ready;

  logic [DATA_W-1:0] s1_mask;
  logic [DATA_W:0]   s1_y;
  logic              s1_mode;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_v    <= 1'b0;
      s1_mask <= '0;
      s1_y    <= '0;
      s1_mode <= 1'b0;
    end else if (adv1) begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        s1_mask <= mask;
        s1_y    <= y_in;
        s1_mode <= bus.in_mode;
      end
    end
  end

  logic [DATA_W:0] mask_ext;
  logic [DATA_W:0] diff;
  logic [DATA_W:0] sum;
  logic [DATA_W:0] res_data;
  logic            res_err;

  always_comb begin
    mask_ext = {1'b0, s1_mask};
    diff     = s1_y - mask_ext;
    sum      = {1'b0, s1_y[DATA_W-1:0]} + mask_ext;
    res_data = '0;
    res_err  = 1'b0;
    if (s1_mode) begin
      res_data = sum;
    end else begin
      res_data = {1'b0, diff[DATA_W-1:0]};
      res_err  = (s1_y < mask_ext);
    end
  end

  logic [DATA_W:0] s2_data;
  logic            s2_err;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s2_v    <= 1'b0;
      s2_data <= '0;
      s2_err  <= 1'b0;
    end else if (adv2) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_data <= res_data;
        s2_err  <= res_err;
      end
    end
  end

  assign bus.out_valid = s2_v;
  assign bus.out_data  = s2_data;
  assign bus.out_err   = s2_err;

  // Clear wins over a coincident handshake; pkt_cnt wraps, err_cnt saturates.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else if (cnt_clr) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else if (out_fire) begin
      pkt_cnt <= pkt_cnt + 1'b1;
      if (s2_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_decrypt_pipe_param.sv
// Scoreboard bench for decrypt_pipe_param: directed vectors plus randomized traffic
// checked against a bit-level mask model and plain modular arithmetic.
module tb_decrypt_pipe_param;
  localparam int unsigned     DATA_W  = 60;
  localparam int unsigned     KEY_W   = 11;
  localparam int unsigned     KEY_LSB = 6;
  localparam int unsigned     NSEG    = 6;
  localparam logic [NSEG-1:0] PATTERN = 6'b010110;
  localparam int unsigned     CNT_W   = 8;

  typedef logic [DATA_W:0] word_t;
  typedef struct {
    word_t d;
    logic  e;
  } exp_t;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] err_cnt;

  decrypt_pipe_param_if #(.DATA_W(DATA_W), .KEY_W(KEY_W), .KEY_LSB(KEY_LSB)) bus ();

  decrypt_pipe_param #(
    .DATA_W(DATA_W), .KEY_W(KEY_W), .KEY_LSB(KEY_LSB),
    .NSEG(NSEG), .PATTERN(PATTERN), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .bus(bus),
    .cnt_clr(cnt_clr), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 Clk = ~Clk;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  int   rdy_mode = 0;
  int   stall_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input word_t d, input logic e);
    exp_t r;
    r.d = d;
    r.e = e;
    return r;
  endfunction

  // Mask bit b is key bit (b mod KEY_W), inverted when its segment's PATTERN bit is set.
  function automatic word_t model_mask(input logic [KEY_W-1:0] key);
    word_t m = '0;
    for (int b = 0; b < int'(DATA_W); b++) begin
      m[b] = key[b % int'(KEY_W)] ^ PATTERN[b / int'(KEY_W)];
    end
    return m;
  endfunction

  function automatic exp_t model(input logic mode, input logic [KEY_W-1:0] key, input word_t y);
    word_t m = model_mask(key);
    word_t p = {1'b0, y[DATA_W-1:0]};
    word_t x;
    exp_t  r;
    if (mode) begin
      r.d = p + m;
      r.e = 1'b0;
    end else begin
      x   = y - m;
      r.d = {1'b0, x[DATA_W-1:0]};
      r.e = (y < m);
    end
    return r;
  endfunction

  task automatic send(input logic mode, input logic [KEY_W-1:0] key, input word_t y, input exp_t e);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_data  = {y, key, KEY_LSB'($urandom)};
    while (n < 200) begin
      @(negedge Clk);
      #1;
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
      stall_seen++;
      n++;
    end
    @(posedge Clk);
    if (ok) sb.push_back(e);
    else begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", n);
    end
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic mode, input logic [KEY_W-1:0] key, input word_t y);
    send(mode, key, y, model(mode, key, y));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge Clk);
      n++;
    end
    check("drain_left", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge Clk);
    #1;
  endtask

  // out_ready (and random cnt_clr) driver
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'b0;
        default: begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          cnt_clr       = ($urandom_range(0, 40) == 0);
        end
      endcase
    end
  end

  // Monitor: samples mid-cycle, before the edge at which the handshake completes.
  initial begin
    word_t pd;
    logic  pe;
    logic  pstall;
    logic  hs;
    int    mp;
    int    me;
    exp_t  ex;
    pd = '0; pe = 1'b0; pstall = 1'b0; mp = 0; me = 0;
    forever begin
      @(negedge Clk);
      #2;
      if (!Rst_n) begin
        sb.delete();
        mp = 0;
        me = 0;
        pstall = 1'b0;
      end else begin
        check("pkt_cnt", 64'(pkt_cnt), 64'(mp));
        check("err_cnt", 64'(err_cnt), 64'(me));
        if (pstall) begin
          check("stall_valid", 64'(bus.out_valid), 64'd1);
          check("stall_data", 64'(bus.out_data), 64'(pd));
          check("stall_err", 64'(bus.out_err), 64'(pe));
        end
        hs = bus.out_valid && bus.out_ready;
        ex = mk('0, 1'b0);
        if (hs) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got data 0x%0h, expected no output", bus.out_data);
          end else begin
            ex = sb.pop_front();
            check("out_data", 64'(bus.out_data), 64'(ex.d));
            check("out_err", 64'(bus.out_err), 64'(ex.e));
          end
        end
        if (cnt_clr) begin
          mp = 0;
          me = 0;
        end else if (hs) begin
          mp = (mp + 1) % (1 << CNT_W);
          if (ex.e && me < (1 << CNT_W) - 1) me++;
        end
        pstall = bus.out_valid && !bus.out_ready;
        pd = bus.out_data;
        pe = bus.out_err;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_err", 64'(bus.out_err), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    #12;
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // 1: all-zero key against its own mask, with latency check
    send(1'b0, 11'h000, 61'h007FF001FFFFF800, mk(61'h0, 1'b0));
    check("lat_s1_valid", 64'(bus.out_valid), 64'd0);
    @(posedge Clk);
    #1;
    check("lat_s2_valid", 64'(bus.out_valid), 64'd1);
    drain();
    check("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);

    // 2: borrow
    send(1'b0, 11'h7FF, 61'h0, mk(61'h007FF001FFFFF801, 1'b1));
    drain();
    check("t2_err_cnt", 64'(err_cnt), 64'd1);

    // 3: encrypt then decrypt round trip
    send(1'b1, 11'h7FF, 61'h1, mk(61'h0F800FFE00000800, 1'b0));
    send(1'b0, 11'h7FF, 61'h0F800FFE00000800, mk(61'h1, 1'b0));
    drain();

    // 4: back-to-back with a mid-stream stall
    stall_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        rdy_mode = 1;
        fork
          begin
            repeat (6) @(posedge Clk);
            rdy_mode = 0;
          end
        join_none
      end
      send_rand(1'($urandom), 11'($urandom), word_t'({$urandom, $urandom}));
    end
    drain();
    check("t4_in_ready_dropped", 64'(stall_seen > 0), 64'd1);
    check("t4_pkt_cnt", 64'(pkt_cnt), 64'd14);

    // 5: clear coincident with an error handshake, then wrap and saturation
    send(1'b0, 11'h7FF, 61'h0, mk(61'h007FF001FFFFF801, 1'b1));
    n = 0;
    while (n < 20) begin
      @(negedge Clk);
      #1;
      if (bus.out_valid) break;
      n++;
    end
    check("t5_valid_seen", 64'(bus.out_valid), 64'd1);
    cnt_clr = 1'b1;
    @(posedge Clk);
    #1;
    cnt_clr = 1'b0;
    check("t5_clr_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("t5_clr_err_cnt", 64'(err_cnt), 64'd0);
    for (int i = 0; i < 255; i++) send_rand(1'b0, 11'h7FF, word_t'($urandom));
    drain();
    check("t5_pkt_cnt_max", 64'(pkt_cnt), 64'hFF);
    check("t5_err_cnt_max", 64'(err_cnt), 64'hFF);
    send_rand(1'b0, 11'h7FF, word_t'($urandom));
    drain();
    check("t5_pkt_cnt_wrap", 64'(pkt_cnt), 64'h0);
    check("t5_err_cnt_sat", 64'(err_cnt), 64'hFF);

    // randomized mixed traffic with random backpressure and clears
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge Clk);
        #1;
      end
      send_rand(1'($urandom), 11'($urandom), word_t'({$urandom, $urandom}));
    end
    rdy_mode = 0;
    @(posedge Clk);
    #2;
    cnt_clr = 1'b0;
    drain();

    // 6: reset with both stages full
    rdy_mode = 1;
    @(posedge Clk);
    #1;
    send_rand(1'b0, 11'($urandom), word_t'({$urandom, $urandom}));
    send_rand(1'b1, 11'($urandom), word_t'({$urandom, $urandom}));
    check("t6_full_valid", 64'(bus.out_valid), 64'd1);
    check("t6_full_in_ready", 64'(bus.in_ready), 64'd0);
    Rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    check("t6_rst_data", 64'(bus.out_data), 64'd0);
    check("t6_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk);
      #1;
      check("t6_no_stale", 64'(bus.out_valid), 64'd0);
    end
    send_rand(1'b0, 11'($urandom), word_t'({$urandom, $urandom}));
    drain();
    check("t6_pkt_cnt", 64'(pkt_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
